cam_sensor_model: RTL and testbench

CAM_SENSOR_MODEL -- requirements
Module: cam_sensor_model

---
 rtl/cam_sensor_model.sv | 106 ++++++++++
 tb/tb_cam_sensor_model.sv | 125 ++++++++++++
 2 files changed

// File: rtl/cam_sensor_model.sv
// cam_sensor_model: behavioural image-sensor pixel model with reset/integrate/sample/convert protocol checking
module cam_sensor_model #(
   parameter int CONV_CYCLES = 16,
   parameter int RST_MIN     = 4,
   parameter int PIX_W       = 12
) (
   input  logic             pix_clk,
   input  logic             rst_FSM,
   input  logic             rst_cam,
   input  logic             sample_cam,
   output logic             end_adc,
   output logic [PIX_W-1:0] pix_data,
   output logic             pix_valid,
   output logic             err_seq
);
   localparam int RW = $clog2(RST_MIN + 1);
   localparam logic [RW-1:0] RMAX = RW'(RST_MIN);
   localparam logic [7:0]    CMAX = 8'(CONV_CYCLES);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_RST    = 3'd1;
   localparam logic [2:0] S_INTEG  = 3'd2;
   localparam logic [2:0] S_SAMPLE = 3'd3;
   localparam logic [2:0] S_CONV   = 3'd4;
   logic [2:0]       r_state;
   logic             r_rst_q, r_smp_q;
   logic [RW-1:0]    r_rcnt;
   logic [7:0]       r_ccnt;
   logic [PIX_W-1:0] r_integ, r_lat;
   logic             w_rst_rise, w_smp_rise;
   assign w_rst_rise = rst_cam & ~r_rst_q;
   assign w_smp_rise = sample_cam & ~r_smp_q;
   // Protocol FSM; the RST exit edge already counts as the first integration cycle
   always_ff @(posedge pix_clk) begin
      if (rst_FSM) begin
         r_state   <= S_IDLE;
         r_rst_q   <= 1'b0;
         r_smp_q   <= 1'b0;
         r_rcnt    <= '0;
         r_ccnt    <= '0;
         r_integ   <= '0;
         r_lat     <= '0;
         end_adc   <= 1'b1;
         pix_data  <= '0;
         pix_valid <= 1'b0;
         err_seq   <= 1'b0;
      end else begin
         r_rst_q   <= rst_cam;
         r_smp_q   <= sample_cam;
         pix_valid <= 1'b0;
         err_seq   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (rst_cam) begin
                  r_state <= S_RST;
                  r_rcnt  <= RW'(1);
               end
               err_seq <= w_smp_rise;
            end
            S_RST: begin
               if (rst_cam) begin
                  if (r_rcnt != RMAX) r_rcnt <= r_rcnt + RW'(1);
                  err_seq <= w_smp_rise;
               end else if (r_rcnt >= RMAX) begin
                  r_state <= S_INTEG;
                  r_integ <= sample_cam ? '0 : PIX_W'(1);
               end else begin
                  r_state <= S_IDLE;
                  err_seq <= 1'b1;
               end
            end
            S_INTEG: begin
               if (rst_cam) begin
                  r_state <= S_RST;
                  r_rcnt  <= RW'(1);
                  err_seq <= w_smp_rise;
               end else if (w_smp_rise) begin
                  r_state <= S_SAMPLE;
                  r_lat   <= r_integ;
               end else if (!sample_cam && r_integ != '1) begin
                  r_integ <= r_integ + PIX_W'(1);
               end
            end
            S_SAMPLE: begin
               err_seq <= w_rst_rise;
               if (!sample_cam) begin
                  r_state <= S_CONV;
                  end_adc <= 1'b0;
                  r_ccnt  <= 8'd1;
               end
            end
            S_CONV: begin
               err_seq <= w_rst_rise | w_smp_rise;
               if (r_ccnt == CMAX) begin
                  r_state   <= S_IDLE;
                  end_adc   <= 1'b1;
                  pix_data  <= r_lat;
                  pix_valid <= 1'b1;
               end else begin
                  r_ccnt <= r_ccnt + 8'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cam_sensor_model.sv
// tb_cam_sensor_model: protocol-level event model checking conversions, errors and timing
module tb_cam_sensor_model;
   logic        pix_clk = 1'b0;
   logic        rst_FSM = 1'b1;
   logic        rst_cam = 1'b0;
   logic        sample_cam = 1'b0;
   logic        end_adc, pix_valid, err_seq;
   logic [11:0] pix_data;
   int n_chk = 0, n_fail = 0;
   int n_valid = 0, n_err = 0, n_long = 0, run = 0, last_run = 0;
   logic prev_v = 1'b0, prev_e = 1'b0;

   cam_sensor_model #(.CONV_CYCLES(16), .RST_MIN(4), .PIX_W(12)) dut (
      .pix_clk(pix_clk), .rst_FSM(rst_FSM), .rst_cam(rst_cam), .sample_cam(sample_cam),
      .end_adc(end_adc), .pix_data(pix_data), .pix_valid(pix_valid), .err_seq(err_seq)
   );

   always #5 pix_clk = ~pix_clk;

   // event monitor: strobe counts, strobe widths and end_adc low-run lengths
   always @(negedge pix_clk) begin
      if (pix_valid === 1'b1) n_valid++;
      if (err_seq === 1'b1) n_err++;
      if ((pix_valid === 1'b1 && prev_v) || (err_seq === 1'b1 && prev_e)) n_long++;
      prev_v = (pix_valid === 1'b1);
      prev_e = (err_seq === 1'b1);
      if (end_adc === 1'b0) run++;
      else if (run != 0) begin
         last_run = run;
         run = 0;
      end
   end

   task automatic cyc(input int n, input logic r, input logic s);
      repeat (n) begin
         @(negedge pix_clk);
         rst_cam = r;
         sample_cam = s;
      end
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      int v0, e0, hi, lo, pre, hi2, sw, exp_pix;
      bit restart, short_rst;
      exp_pix = 0;
      cyc(3, 0, 0);
      chk("rst_end_adc", int'(end_adc), 1);
      chk("rst_pix_data", int'(pix_data), 0);
      chk("rst_pix_valid", int'(pix_valid), 0);
      chk("rst_err_seq", int'(err_seq), 0);
      rst_FSM = 1'b0;

      v0 = n_valid; e0 = n_err;
      cyc(8, 1, 0); cyc(20, 0, 0); cyc(4, 0, 1); cyc(24, 0, 0);
      exp_pix = 20;
      chk("basic_pix", int'(pix_data), exp_pix);
      chk("basic_valid", n_valid - v0, 1);
      chk("basic_err", n_err - e0, 0);
      chk("basic_conv_len", last_run, 16);
      chk("basic_end_adc", int'(end_adc), 1);

      for (int i = 0; i < 6; i++) begin
         hi = $urandom_range(4, 10);
         lo = $urandom_range(1, 80);
         sw = $urandom_range(1, 5);
         restart = 1'($urandom_range(0, 1));
         pre = $urandom_range(1, 20);
         hi2 = $urandom_range(1, 7);
         short_rst = restart && hi2 < 4;
         v0 = n_valid; e0 = n_err; last_run = 0;
         cyc(hi, 1, 0);
         if (restart) begin
            cyc(pre, 0, 0);
            cyc(hi2, 1, 0);
         end
         cyc(lo, 0, 0); cyc(sw, 0, 1); cyc(24, 0, 0);
         if (!short_rst) exp_pix = (lo > 4095) ? 4095 : lo;
         chk($sformatf("rand%0d_pix", i), int'(pix_data), exp_pix);
         chk($sformatf("rand%0d_valid", i), n_valid - v0, short_rst ? 0 : 1);
         chk($sformatf("rand%0d_err", i), n_err - e0, short_rst ? 2 : 0);
         chk($sformatf("rand%0d_conv_len", i), last_run, short_rst ? 0 : 16);
      end

      v0 = n_valid; e0 = n_err; last_run = 0;
      cyc(2, 1, 0); cyc(10, 0, 0); cyc(3, 0, 1); cyc(30, 0, 0);
      chk("short_err", n_err - e0, 2);
      chk("short_valid", n_valid - v0, 0);
      chk("short_no_conv", last_run + run, 0);
      chk("short_pix_held", int'(pix_data), exp_pix);

      cyc(8, 1, 0); cyc(5000, 0, 0); cyc(2, 0, 1); cyc(24, 0, 0);
      exp_pix = 4095;
      chk("sat_pix", int'(pix_data), exp_pix);

      v0 = n_valid; e0 = n_err; last_run = 0;
      cyc(8, 1, 0); cyc(12, 0, 0); cyc(2, 0, 1); cyc(5, 0, 0); cyc(1, 0, 1); cyc(24, 0, 0);
      exp_pix = 12;
      chk("conv_cmd_err", n_err - e0, 1);
      chk("conv_cmd_len", last_run, 16);
      chk("conv_cmd_pix", int'(pix_data), exp_pix);
      chk("conv_cmd_valid", n_valid - v0, 1);

      v0 = n_valid;
      cyc(8, 1, 0); cyc(10, 0, 0); cyc(2, 0, 1); cyc(8, 0, 0);
      rst_FSM = 1'b1;
      @(negedge pix_clk);
      rst_FSM = 1'b0;
      chk("abort_end_adc", int'(end_adc), 1);
      chk("abort_pix", int'(pix_data), 0);
      cyc(30, 0, 0);
      chk("abort_valid", n_valid - v0, 0);
      chk("strobe_width", n_long, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
